serial_bit_feeder: RTL and testbench

//   Upstream stage of the 1010 Mealy sequence detector: accepts parallel words over a

---
 rtl/serial_bit_feeder.sv | 206 ++++++++++++++++++++
 tb/tb_serial_bit_feeder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// serial_bit_feeder
//
// Front end of the 1010 Mealy sequence detector. Parallel words arrive over a
// valid/ready handshake and are shifted out one bit per clock on bit_out,
// which drives the detector's data_in. A one-word holding buffer lets a second
// word be accepted while the first is still shifting. The buffered word then
// follows the first with no idle bit between them, so a pattern that spans a
// word boundary still reaches the detector intact.
//
// Parameters
//   WIDTH      bits per word (>= 2)
//   LSB_FIRST  0: MSB leaves first, 1: LSB leaves first
//   IDLE_BIT   level driven on bit_out while no data bit is valid
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous reset, active-high
//   word_in     parallel word, sampled only on an accepting edge
//   word_valid  word_in is valid
//   word_ready  feeder accepts word_in this cycle (combinational)
//   abort       synchronous flush of the shifter and the buffer
//   bit_out     serial data bit
//   bit_valid   bit_out carries a data bit
//   last_bit    bit_out is the final bit of its word
//   busy        shifter or buffer holds data
// -----------------------------------------------------------------------------
module serial_bit_feeder #(
  parameter int   WIDTH     = 8,
  parameter int   LSB_FIRST = 0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic             abort,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             last_bit,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST_LOAD = CNT_W'(WIDTH - 1);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;   // bits still to send, next one at MSB
  logic [WIDTH-1:0] buf_reg, buf_next;       // holding buffer, already in send order
  logic             buf_full_reg, buf_full_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;       // bits left after the one on bit_out
  logic             bit_out_reg, bit_out_next;
  logic             bit_valid_reg, bit_valid_next;
  logic             last_bit_reg, last_bit_next;
  logic             busy_reg, busy_next;

  // word_in rearranged so that the first bit to send is always the MSB;
  // everything downstream then shifts left regardless of LSB_FIRST.
  logic [WIDTH-1:0] word_ordered;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      if (LSB_FIRST != 0) begin : g_lsb
        assign word_ordered[WIDTH-1-gi] = word_in[gi];
      end else begin : g_msb
        assign word_ordered[gi] = word_in[gi];
      end
    end
  endgenerate

  // A full buffer blocks new words; abort also blocks them so nothing is
  // accepted in the same cycle that is being flushed.
  assign word_ready = ~buf_full_reg & ~abort;

  logic             xfer;
  logic             load_en;
  logic [WIDTH-1:0] load_word;

  assign xfer = word_valid & word_ready;

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    buf_next       = buf_reg;
    buf_full_next  = buf_full_reg;
    cnt_next       = cnt_reg;
    bit_out_next   = bit_out_reg;
    bit_valid_next = bit_valid_reg;
    last_bit_next  = last_bit_reg;
    load_en        = 1'b0;
    load_word      = word_ordered;

    if (abort) begin
      // Flush wins over any load or buffer move in this cycle.
      state_next     = ST_IDLE;
      shift_next     = '0;
      buf_next       = '0;
      buf_full_next  = 1'b0;
      cnt_next       = '0;
      bit_out_next   = IDLE_BIT;
      bit_valid_next = 1'b0;
      last_bit_next  = 1'b0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (xfer) begin
            load_en   = 1'b1;
            load_word = word_ordered;
          end
        end

        ST_SHIFT: begin
          if (cnt_reg == '0) begin
            // The final bit is on the output. Chain the next word straight
            // behind it. A buffered word has priority, and word_ready is low
            // while the buffer is full, so the two cannot collide.
            if (buf_full_reg) begin
              load_en       = 1'b1;
              load_word     = buf_reg;
              buf_full_next = 1'b0;
            end else if (xfer) begin
              load_en   = 1'b1;
              load_word = word_ordered;
            end else begin
              state_next     = ST_IDLE;
              shift_next     = '0;
              bit_out_next   = IDLE_BIT;
              bit_valid_next = 1'b0;
              last_bit_next  = 1'b0;
            end
          end else begin
            bit_out_next   = shift_reg[WIDTH-1];
            shift_next     = {shift_reg[WIDTH-2:0], 1'b0};
            cnt_next       = cnt_reg - CNT_W'(1);
            bit_valid_next = 1'b1;
            last_bit_next  = (cnt_reg == CNT_W'(1));
            if (xfer) begin
              buf_next      = word_ordered;
              buf_full_next = 1'b1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase

      if (load_en) begin
        // The first bit of the word goes straight onto bit_out. The rest wait
        // in the shifter. WIDTH >= 2, so a freshly loaded word is never on its
        // last bit.
        state_next     = ST_SHIFT;
        bit_out_next   = load_word[WIDTH-1];
        shift_next     = {load_word[WIDTH-2:0], 1'b0};
        cnt_next       = CNT_LAST_LOAD;
        bit_valid_next = 1'b1;
        last_bit_next  = 1'b0;
      end
    end

    busy_next = (state_next == ST_SHIFT) | buf_full_next;
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      shift_reg     <= '0;
      buf_reg       <= '0;
      buf_full_reg  <= 1'b0;
      cnt_reg       <= '0;
      bit_out_reg   <= IDLE_BIT;
      bit_valid_reg <= 1'b0;
      last_bit_reg  <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      buf_reg       <= buf_next;
      buf_full_reg  <= buf_full_next;
      cnt_reg       <= cnt_next;
      bit_out_reg   <= bit_out_next;
      bit_valid_reg <= bit_valid_next;
      last_bit_reg  <= last_bit_next;
      busy_reg      <= busy_next;
    end
  end

  assign bit_out   = bit_out_reg;
  assign bit_valid = bit_valid_reg;
  assign last_bit  = last_bit_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_bit_feeder
//
// Two instances of the feeder are used. The main one is MSB-first with
// IDLE_BIT=0. The second one is LSB-first with IDLE_BIT=1.
//
// The main instance is checked every cycle against a stream model. Every
// accepted word appends its bits to a queue in send order. On each edge one
// bit is popped onto the output. The buffer counts as full when at least
// WIDTH bits remain queued behind the bit that is on the output.
// -----------------------------------------------------------------------------
module tb_serial_bit_feeder;

  localparam int   W        = 8;
  localparam logic IDLE_M   = 1'b0;
  localparam logic IDLE_L   = 1'b1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main DUT (MSB first, IDLE_BIT=0)
  logic [W-1:0] word_in;
  logic         word_valid, word_ready, abort;
  logic         bit_out, bit_valid, last_bit, busy;

  // secondary DUT (LSB first, IDLE_BIT=1)
  logic [W-1:0] word_in_l;
  logic         word_valid_l, word_ready_l, abort_l;
  logic         bit_out_l, bit_valid_l, last_bit_l, busy_l;

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(0), .IDLE_BIT(IDLE_M)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .abort      (abort),
    .bit_out    (bit_out),
    .bit_valid  (bit_valid),
    .last_bit   (last_bit),
    .busy       (busy)
  );

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(1), .IDLE_BIT(IDLE_L)) u_dut_lsb (
    .clk        (clk),
    .rst        (rst),
    .word_in    (word_in_l),
    .word_valid (word_valid_l),
    .word_ready (word_ready_l),
    .abort      (abort_l),
    .bit_out    (bit_out_l),
    .bit_valid  (bit_valid_l),
    .last_bit   (last_bit_l),
    .busy       (busy_l)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_value(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [1:0] m_q[$];          // {is_last, bit}, in send order
  logic       m_bit, m_valid, m_last, m_busy;
  logic       obs_bits[$];     // observed valid bits of the main DUT
  logic       obs_last[$];
  int         cycle_no = 0;
  int         first_valid_cyc, last_valid_cyc;

  task automatic model_clear();
    m_q.delete();
    m_bit   = IDLE_M;
    m_valid = 1'b0;
    m_last  = 1'b0;
    m_busy  = 1'b0;
  endtask

  // One clock of the main DUT: drive inputs at the falling edge, check
  // word_ready, advance the model, then check the registered outputs at the
  // next falling edge.
  task automatic cycle(input logic v, input logic [W-1:0] w, input logic ab,
                       output logic took);
    logic [1:0] e;
    word_valid = v;
    word_in    = w;
    abort      = ab;
    #1;
    took = v && !ab && (m_q.size() < W);
    check_value("word_ready", word_ready, !ab && (m_q.size() < W));
    if (ab) m_q.delete();
    else if (took)
      for (int i = 0; i < W; i++) m_q.push_back({(i == W-1), w[W-1-i]});
    if (m_q.size() > 0) begin
      e       = m_q.pop_front();
      m_valid = 1'b1;
      m_bit   = e[0];
      m_last  = e[1];
    end else begin
      m_valid = 1'b0;
      m_bit   = IDLE_M;
      m_last  = 1'b0;
    end
    m_busy = m_valid || (m_q.size() >= W);
    @(posedge clk);
    @(negedge clk);
    cycle_no++;
    check_value("bit_valid", bit_valid, m_valid);
    check_value("bit_out",   bit_out,   m_bit);
    check_value("last_bit",  last_bit,  m_last);
    check_value("busy",      busy,      m_busy);
    $display("cyc %0d v=%0b w=%02h ab=%0b took=%0b -> bit=%0b valid=%0b last=%0b busy=%0b",
             cycle_no, v, w, ab, took, bit_out, bit_valid, last_bit, busy);
    if (bit_valid) begin
      obs_bits.push_back(bit_out);
      obs_last.push_back(last_bit);
      if (first_valid_cyc < 0) first_valid_cyc = cycle_no;
      last_valid_cyc = cycle_no;
    end
    word_valid = 1'b0;
  endtask

  // Sends one word, holding word_valid until it is accepted (bounded).
  task automatic send_word(input logic [W-1:0] w);
    logic took;
    took = 1'b0;
    for (int k = 0; k < 20 && !took; k++) cycle(1'b1, w, 1'b0, took);
    check_value("accept_timeout", took, 1'b1);
  endtask

  task automatic idle_cycles(input int n);
    logic took;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, 1'b0, took);
  endtask

  task automatic obs_clear();
    obs_bits.delete();
    obs_last.delete();
    first_valid_cyc = -1;
    last_valid_cyc  = -1;
  endtask

  function automatic int count_1010();
    int n = 0;
    for (int i = 3; i < obs_bits.size(); i++)
      if (obs_bits[i-3] && !obs_bits[i-2] && obs_bits[i-1] && !obs_bits[i]) n++;
    return n;
  endfunction

  function automatic logic [15:0] obs_word(input int n, input logic use_last);
    logic [15:0] r = '0;
    for (int i = 0; i < n && i < obs_bits.size(); i++)
      r = {r[14:0], use_last ? obs_last[i] : obs_bits[i]};
    return r;
  endfunction

  // ---------------------------------------------------------------- main
  initial begin
    logic         took, have;
    logic [W-1:0] pend;
    int           vprob;

    rst = 1'b1;
    word_in = '0; word_valid = 1'b0; abort = 1'b0;
    word_in_l = '0; word_valid_l = 1'b0; abort_l = 1'b0;
    model_clear();
    obs_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_value("reset_bit_valid", bit_valid, 1'b0);
    check_value("reset_busy",      busy,      1'b0);
    check_value("reset_last_bit",  last_bit,  1'b0);
    check_value("reset_bit_out",   bit_out,   IDLE_M);
    check_value("reset_word_ready", word_ready, 1'b1);
    check_value("reset_lsb_bit_out", bit_out_l, IDLE_L);
    rst = 1'b0;

    // Single word A5, MSB first.
    obs_clear();
    send_word(8'hA5);
    idle_cycles(10);
    check_value("a5_count", obs_bits.size(), 8);
    check_value("a5_bits",  obs_word(8, 1'b0), 16'h00A5);
    check_value("a5_last",  obs_word(8, 1'b1), 16'h0001);

    // Back-to-back AA then 0A: 16 contiguous bits, overlapping 1010 matches.
    obs_clear();
    send_word(8'hAA);
    send_word(8'h0A);
    idle_cycles(20);
    check_value("b2b_count", obs_bits.size(), 16);
    check_value("b2b_span",  last_valid_cyc - first_valid_cyc + 1, 16);
    check_value("b2b_bits",  obs_word(16, 1'b0), 16'hAA0A);
    check_value("b2b_1010",  count_1010(), 4);

    // Abort with the buffer full: both words are dropped.
    obs_clear();
    send_word(8'h3C);
    send_word(8'hC3);
    idle_cycles(1);
    cycle(1'b1, 8'h77, 1'b1, took);
    check_value("abort_took",  took, 1'b0);
    check_value("abort_valid", bit_valid, 1'b0);
    check_value("abort_busy",  busy, 1'b0);
    idle_cycles(12);
    check_value("abort_bits_seen", obs_bits.size(), 3);

    // Reset asserted between edges while shifting takes effect immediately.
    send_word(8'hFF);
    idle_cycles(2);
    #2 rst = 1'b1;
    #1;
    check_value("mid_rst_valid", bit_valid, 1'b0);
    check_value("mid_rst_busy",  busy, 1'b0);
    check_value("mid_rst_last",  last_bit, 1'b0);
    check_value("mid_rst_bit",   bit_out, IDLE_M);
    check_value("mid_rst_ready", word_ready, 1'b1);
    model_clear();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // LSB-first instance with word 01; the main DUT idles alongside.
    word_in_l = 8'h01; word_valid_l = 1'b1;
    #1 check_value("lsb_ready", word_ready_l, 1'b1);
    idle_cycles(1);
    word_valid_l = 1'b0;
    for (int i = 0; i < W; i++) begin
      check_value("lsb_valid", bit_valid_l, 1'b1);
      check_value("lsb_bit",   bit_out_l, (i == 0));
      check_value("lsb_last",  last_bit_l, (i == W-1));
      idle_cycles(1);
    end
    check_value("lsb_end_valid", bit_valid_l, 1'b0);
    check_value("lsb_end_idle",  bit_out_l, IDLE_L);

    // Randomized traffic with word_valid held until accepted and rare aborts.
    have = 1'b0;
    pend = '0;
    for (int n = 0; n < 3000; n++) begin
      vprob = (n / 500) % 2 ? 90 : 30;
      if (!have && $urandom_range(99) < vprob) begin
        pend = W'($urandom);
        have = 1'b1;
      end
      cycle(have, pend, ($urandom_range(59) == 0), took);
      if (took) have = 1'b0;
    end
    idle_cycles(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
